// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: request/response handshake bundle for the multi-word sequential adder
interface mp_add_seq_if #(parameter int NWORDS = 4);
  logic in_valid;
  logic in_ready;
  logic [16*NWORDS-1:0] op_a;
  logic [16*NWORDS-1:0] op_b;
  logic op_cin;
  logic out_valid;
  logic out_ready;
  logic [16*NWORDS-1:0] sum;
  logic cout;
  modport master (output in_valid, op_a, op_b, op_cin, out_ready, input in_ready, out_valid, sum, cout);
  modport slave (input in_valid, op_a, op_b, op_cin, out_ready, output in_ready, out_valid, sum, cout);
endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-word adder that streams one 16-bit word per cycle through an external adder
module mp_add_seq #(parameter int NWORDS = 4) (
  input  logic clk,
  input  logic rst_n,
  mp_add_seq_if.slave bus,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic add_cin,
  input  logic [15:0] add_s,
  input  logic add_cout
);
  localparam int IW = $clog2(NWORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [16*NWORDS-1:0] a_r, b_r, sum_r;
  logic carry, cout_r;
  logic last;
  assign last = idx == IW'(NWORDS - 1);
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.in_valid) state_nx = RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE && bus.out_ready) state_nx = IDLE;
  end
  // The external adder sees live data only while a word is being processed.
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    add_a = state == RUN ? a_r[16*idx +: 16] : 16'h0;
    add_b = state == RUN ? b_r[16*idx +: 16] : 16'h0;
    add_cin = state == RUN ? carry : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      cout_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        a_r <= bus.op_a;
        b_r <= bus.op_b;
        carry <= bus.op_cin;
        idx <= '0;
      end
      if (state == RUN) begin
        sum_r[16*idx +: 16] <= add_s;
        carry <= add_cout;
        if (last) cout_r <= add_cout;
        else idx <= idx + 1'b1;
      end
    end
  end
  assign bus.sum = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed vectors with a scoreboard queue checked by a decoupled output monitor
module tb_mp_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] add_a, add_b, add_s;
  logic add_cin, add_cout;
  int n_chk = 0;
  int n_fail = 0;
  logic [64:0] exp_q[$];
  mp_add_seq_if #(.NWORDS(4)) bus ();
  mp_add_seq #(.NWORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", {bus.cout, bus.sum}, 65'h1_dead_dead_dead_dead);
      else chk("result", {bus.cout, bus.sum}, exp_q.pop_front());
    end
  end
  task automatic run_req(input logic [63:0] a, input logic [63:0] b, input logic cin,
                         input logic [64:0] req, input int hold, input bit noisy);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 65'(bus.in_ready), 65'd1);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_cin = cin;
    bus.out_ready = hold == 0;
    @(posedge clk); #1;
    exp_q.push_back(req);
    if (noisy) begin
      bus.op_a = ~a;
      bus.op_b = ~b;
      bus.op_cin = 1'b0;
    end else begin
      bus.in_valid = 1'b0;
      bus.op_a = '1;
      bus.op_b = '1;
      bus.op_cin = 1'b1;
    end
    n = 0;
    while (!bus.out_valid && n < 20) begin
      chk("in_ready_busy", 65'(bus.in_ready), 65'd0);
      @(posedge clk); #1; n++;
    end
    chk("latency", 65'(n), 65'd4);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, bus.out_valid, bus.in_ready}, 65'b10);
      chk("hold_data", {bus.cout, bus.sum}, req);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", {63'd0, bus.out_valid, bus.in_ready}, 65'b01);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_cin = 1'b0;
    bus.out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_flags", {63'd0, bus.out_valid, bus.in_ready}, 65'b01);
    chk("reset_sum", {bus.cout, bus.sum}, 65'd0);
    chk("reset_adder", {32'd0, add_a, add_b, add_cin}, 65'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_req(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 65'h0_0000_0000_0001_0000, 0, 1'b0);
    run_req(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 65'h1_0000_0000_0000_0000, 0, 1'b0);
    run_req(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    run_req(64'h0, 64'h0, 1'b1, 65'h0_0000_0000_0000_0001, 0, 1'b0);
    run_req(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 65'h0_1234_5678_9ABC_DF00, 3, 1'b0);
    run_req(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 65'h1_0000_0000_0000_0000, 0, 1'b1);
    run_req(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 65'h0_FFFF_FFFF_FFFF_FFFE, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.op_a = 64'hAAAA_BBBB_CCCC_DDDD;
    bus.op_b = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("abort_running", 65'(add_a != 16'h0), 65'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {63'd0, bus.out_valid, bus.in_ready}, 65'b01);
    chk("abort_sum", {bus.cout, bus.sum}, 65'd0);
    chk("abort_adder", {32'd0, add_a, add_b, add_cin}, 65'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 65'(bus.out_valid), 65'd0);
    end
    run_req(64'h1234, 64'h0001, 1'b0, 65'h0_0000_0000_0000_1235, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 65'(exp_q.size()), 65'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
